// File: rtl/mdu_scheduler_pkg.sv
// Shared MDU definitions: operation encodings, FSM states and op-class helpers.
// MADD/MADDU encodings always exist; the scheduler only honours them under MDU_MADD_EN.
package mdu_scheduler_pkg;

    localparam int MDUOP_SIZE = 4;

    typedef enum logic [MDUOP_SIZE-1:0] {
        MDUOP_NONE  = 4'd0,
        MDUOP_MULT  = 4'd1,
        MDUOP_MULTU = 4'd2,
        MDUOP_DIV   = 4'd3,
        MDUOP_DIVU  = 4'd4,
        MDUOP_MTHI  = 4'd5,
        MDUOP_MTLO  = 4'd6,
        MDUOP_MFHI  = 4'd7,
        MDUOP_MFLO  = 4'd8,
        MDUOP_MADD  = 4'd9,
        MDUOP_MADDU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic op_is_mul(input logic [MDUOP_SIZE-1:0] op);
        return (op == MDUOP_MULT) || (op == MDUOP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [MDUOP_SIZE-1:0] op);
        return (op == MDUOP_DIV) || (op == MDUOP_DIVU);
    endfunction

    function automatic logic op_is_madd(input logic [MDUOP_SIZE-1:0] op);
        return (op == MDUOP_MADD) || (op == MDUOP_MADDU);
    endfunction

endpackage

// File: rtl/mdu_scheduler_arith.sv
// mdu_arith: combinational multiply/divide datapath producing {hi_next, lo_next}.
// Divide results follow truncation toward zero; remainder takes the dividend's sign.
module mdu_arith
    import mdu_scheduler_pkg::*;
(
    input  logic [MDUOP_SIZE-1:0] op,
    input  logic [31:0]           operand_a,
    input  logic [31:0]           operand_b,
    output logic [31:0]           hi_next,
    output logic [31:0]           lo_next,
    output logic                  div_by_zero
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;
    logic        [63:0] prod;
    logic               signed_op;
    logic               b_zero;

    always_comb begin
        a_s       = $signed(operand_a);
        b_s       = $signed(operand_b);
        signed_op = (op == MDUOP_MULT) || (op == MDUOP_DIV) || (op == MDUOP_MADD);
        b_zero    = (operand_b == 32'd0);
        div_by_zero = op_is_div(op) && b_zero;

        // Low 64 bits of a product of sign-extended operands equal the signed product.
        if (signed_op)
            prod = {{32{operand_a[31]}}, operand_a} * {{32{operand_b[31]}}, operand_b};
        else
            prod = {32'd0, operand_a} * {32'd0, operand_b};

        q_s = '0;
        r_s = '0;
        q_u = '0;
        r_u = '0;
        if (!b_zero) begin
            // -2^31 / -1 overflows; pin it to the architecturally defined result.
            if ((operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF)) begin
                q_s = a_s;
                r_s = '0;
            end else begin
                q_s = a_s / b_s;
                r_s = a_s % b_s;
            end
            q_u = operand_a / operand_b;
            r_u = operand_a % operand_b;
        end

        hi_next = prod[63:32];
        lo_next = prod[31:0];
        if (op == MDUOP_DIV) begin
            hi_next = r_s;
            lo_next = q_s;
        end else if (op == MDUOP_DIVU) begin
            hi_next = r_u;
            lo_next = q_u;
        end
    end

endmodule

// File: rtl/mdu_scheduler.sv
// E-stage MDU scheduler: owns HI/LO, times the fixed mult/div busy window, raises D-stage stalls.
// Optional MDU_MADD_EN: accepts MADD/MADDU (accumulate product into {hi,lo} at completion).
module mdu_scheduler
    import mdu_scheduler_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MDUOP_SIZE-1:0] op,
    input  logic [31:0]           operand_a,
    input  logic [31:0]           operand_b,
    input  logic                  D_md_use,
    output logic                  busy,
    output logic                  stall_req,
    output logic [31:0]           hi,
    output logic [31:0]           lo,
    output logic [31:0]           mf_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [63:0]        res_q;
    logic               acc_q;
    logic               dz_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    logic [31:0]        hi_next;
    logic [31:0]        lo_next;
    logic               div_by_zero;
    logic               is_mul;
    logic               is_div;
    logic               is_madd;
    logic               is_long;

    mdu_arith u_arith (
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .hi_next     (hi_next),
        .lo_next     (lo_next),
        .div_by_zero (div_by_zero)
    );

    assign is_mul = op_is_mul(op);
    assign is_div = op_is_div(op);
`ifdef MDU_MADD_EN
    assign is_madd = op_is_madd(op);
`else
    assign is_madd = 1'b0;
`endif
    assign is_long = is_mul || is_div || is_madd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            acc_q   <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (start) begin
                        if (is_mul || is_madd) begin
                            res_q   <= {hi_next, lo_next};
                            acc_q   <= is_madd;
                            dz_q    <= 1'b0;
                            cnt_q   <= CNT_W'(MULT_CYCLES);
                            state_q <= MDU_BUSY;
                        end else if (is_div) begin
                            res_q   <= {hi_next, lo_next};
                            acc_q   <= 1'b0;
                            dz_q    <= div_by_zero;
                            cnt_q   <= CNT_W'(DIV_CYCLES);
                            state_q <= MDU_BUSY;
                        end else if (op == MDUOP_MTHI) begin
                            hi_q <= operand_a;
                        end else if (op == MDUOP_MTLO) begin
                            lo_q <= operand_a;
                        end
                    end
                end
                MDU_BUSY: begin
                    // New starts are dropped here; the hazard stall keeps them out.
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= MDU_IDLE;
                        if (acc_q)
                            {hi_q, lo_q} <= {hi_q, lo_q} + res_q;
                        else if (!dz_q)
                            {hi_q, lo_q} <= res_q;
                    end
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == MDU_BUSY);
    assign stall_req = D_md_use && (busy || (start && is_long));
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign mf_data   = (op == MDUOP_MFHI) ? hi_q :
                       (op == MDUOP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Randomized self-checking bench for mdu_scheduler against a plain-arithmetic HI/LO model.
// Build with +define+MDU_MADD_EN to exercise the MADD/MADDU option.
module tb_mdu_scheduler;
    import mdu_scheduler_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [MDUOP_SIZE-1:0] op;
    logic [31:0]           operand_a;
    logic [31:0]           operand_b;
    logic                  D_md_use;
    logic                  busy;
    logic                  stall_req;
    logic [31:0]           hi;
    logic [31:0]           lo;
    logic [31:0]           mf_data;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .D_md_use  (D_md_use),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .mf_data   (mf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int latency(input logic [3:0] o);
        if (o == MDUOP_MULT || o == MDUOP_MULTU) return MC;
        if (o == MDUOP_DIV || o == MDUOP_DIVU) return DC;
`ifdef MDU_MADD_EN
        if (o == MDUOP_MADD || o == MDUOP_MADDU) return MC;
`endif
        return 0;
    endfunction

    // Architectural effect of a completed operation on {hi,lo}.
    task automatic model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MDUOP_MULT:  {hi_m, lo_m} = sx * sy;
            MDUOP_MULTU: {hi_m, lo_m} = ux * uy;
`ifdef MDU_MADD_EN
            MDUOP_MADD:  {hi_m, lo_m} = {hi_m, lo_m} + 64'(sx * sy);
            MDUOP_MADDU: {hi_m, lo_m} = {hi_m, lo_m} + ux * uy;
`endif
            MDUOP_DIV: if (y != 0) begin
                lo_m = 32'(sx / sy);
                hi_m = 32'(sx % sy);
            end
            MDUOP_DIVU: if (y != 0) begin
                lo_m = x / y;
                hi_m = x % y;
            end
            MDUOP_MTHI: hi_m = x;
            MDUOP_MTLO: lo_m = x;
            default: ;
        endcase
    endtask

    task automatic run_long(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int bc, sc, cyc, n;
        n = latency(o);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = x; operand_b = y; D_md_use = 1'b1;
        #1;
        sc = stall_req ? 1 : 0;
        @(negedge clk);
        start = 1'b0; op = MDUOP_NONE;
        #1;
        bc = 0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            bc++;
            if (stall_req) sc++;
            @(negedge clk);
            #1;
            cyc++;
        end
        model_op(o, x, y);
        chk({tag, "_busy"}, 64'(bc), 64'(n));
        chk({tag, "_stall"}, 64'(sc), 64'((n > 0) ? n + 1 : 0));
        chk({tag, "_hi"}, 64'(hi), 64'(hi_m));
        chk({tag, "_lo"}, 64'(lo), 64'(lo_m));
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] x);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = x; D_md_use = 1'b0;
        @(negedge clk);
        start = 1'b0; op = MDUOP_NONE;
        #1;
        model_op(o, x, 32'd0);
        chk("mt_busy", 64'(busy), 64'd0);
        chk("mt_hi", 64'(hi), 64'(hi_m));
        chk("mt_lo", 64'(lo), 64'(lo_m));
    endtask

    task automatic mf(input logic [3:0] o);
        @(negedge clk);
        start = 1'b1; op = o; D_md_use = 1'b1;
        #1;
        chk("mf_data", 64'(mf_data), 64'((o == MDUOP_MFHI) ? hi_m : lo_m));
        chk("mf_nostall", 64'(stall_req), 64'd0);
        @(negedge clk);
        start = 1'b0; op = MDUOP_NONE;
        #1;
        chk("mf_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [3:0]  ops [6];
        logic [3:0]  o;
        logic [31:0] x, y;
        ops[0] = MDUOP_MULT; ops[1] = MDUOP_MULTU; ops[2] = MDUOP_DIV;
        ops[3] = MDUOP_DIVU; ops[4] = MDUOP_MTHI;  ops[5] = MDUOP_MTLO;

        reset = 1'b0; start = 1'b0; op = MDUOP_NONE;
        operand_a = '0; operand_b = '0; D_md_use = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        reset = 1'b1;

        run_long("mult_neg", MDUOP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        run_long("divu", MDUOP_DIVU, 32'd100, 32'd7);
        run_long("div_neg", MDUOP_DIV, 32'hFFFF_FFF9, 32'd2);
        mt(MDUOP_MTHI, 32'h1234);
        mt(MDUOP_MTLO, 32'h5678);
        run_long("div_zero", MDUOP_DIV, 32'hDEAD_BEEF, 32'd0);
        run_long("div_ovf", MDUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        mf(MDUOP_MFLO);
        mf(MDUOP_MFHI);

        // Reset asserted on the third busy cycle aborts the operation.
        @(negedge clk);
        start = 1'b1; op = MDUOP_MULTU; operand_a = 32'hFFFF_0001; operand_b = 32'h0003_0007;
        @(negedge clk);
        start = 1'b0; op = MDUOP_NONE; D_md_use = 1'b0;
        #1;
        chk("abort_busy1", 64'(busy), 64'd1);
        chk("idle_d_nostall", 64'(stall_req), 64'd0);
        @(negedge clk);
        D_md_use = 1'b1;
        #1;
        chk("busy_stall", 64'(stall_req), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        hi_m = 32'd0;
        lo_m = 32'd0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        repeat (8) @(negedge clk);
        #1;
        chk("abort_late_busy", 64'(busy), 64'd0);
        chk("abort_late_hilo", {hi, lo}, 64'd0);

        mt(MDUOP_MTHI, 32'd0);
        mt(MDUOP_MTLO, 32'hFFFF_FFFF);
        run_long("maddu", MDUOP_MADDU, 32'd1, 32'd1);
        run_long("madd", MDUOP_MADD, 32'hFFFF_FFFF, 32'd3);

        for (int i = 0; i < 24; i++) begin
            o = ops[$urandom_range(5, 0)];
            x = $urandom;
            y = $urandom;
            case ($urandom_range(7, 0))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = 32'(1 + $urandom_range(15, 0));
                default: ;
            endcase
            if (o == MDUOP_MTHI || o == MDUOP_MTLO)
                mt(o, x);
            else
                run_long("rand", o, x, y);
            mf(($urandom_range(1, 0) == 0) ? MDUOP_MFHI : MDUOP_MFLO);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
